// File: rtl/coin_payout.sv
// coin_payout
// Change-dispensing back end. Accepts a change amount (cents, 5-cent units),
// pays it out greedily as 20/10/5 coins through a one-coin-at-a-time
// valid/ack handshake to the hopper, and tracks per-denomination tube counts.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_valid         change request valid (accepted only while req_ready)
//   req_amount        amount to pay out
//   req_ready         high in IDLE only
//   coin_out          coin being paid: 01=5, 10=10, 11=20, 00=none
//   coin_valid        coin_out valid, held until coin_ack
//   coin_ack          hopper released the coin (ignored outside EMIT)
//   done              one-cycle pulse at end of payout
//   short             with done: a remainder was left unpaid
//   remaining         unpaid amount, held until the next request is accepted
//   refill_valid      one coin inserted into a tube
//   refill_coin       denomination of the refill coin (coin_out encoding)
//   refill_overflow   one-cycle pulse: refill into a full tube was discarded
//   tube_empty        bit0=5, bit1=10, bit2=20 tube is empty
//   low_change        any tube count <= LOW_THRESH
module coin_payout #(
    parameter int TUBE_INIT  = 10,
    parameter int TUBE_MAX   = 15,
    parameter int LOW_THRESH = 2,
    parameter int AMT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    output logic             refill_overflow,
    output logic [2:0]       tube_empty,
    output logic             low_change
);

    localparam int CNT_W = $clog2(TUBE_MAX + 1);

    typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

    state_t           state_reg;
    logic [AMT_W-1:0] rem_reg;
    logic [AMT_W-1:0] remaining_reg;
    logic [1:0]       coin_out_reg;
    logic             coin_valid_reg;
    logic             done_reg;
    logic             short_reg;

    // Tube index gi holds the coin whose code is gi+1 (0=5, 1=10, 2=20).
    logic [CNT_W-1:0] tube_cnt [3];
    logic [2:0]       tube_dec;
    logic [2:0]       tube_inc;
    logic [2:0]       tube_low;
    logic [2:0]       tube_ovf;
    logic [1:0]       pick_code;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   coin_value = AMT_W'(5);
            2'b10:   coin_value = AMT_W'(10);
            2'b11:   coin_value = AMT_W'(20);
            default: coin_value = '0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tube
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;

            // The decrement is tied to the coin actually being emitted, so a
            // tube is never decremented below zero: it was non-empty at pick
            // time and nothing else removes coins.
            assign tube_dec[gi] = (state_reg == EMIT) && coin_ack &&
                                  (coin_out_reg == 2'(gi + 1));
            assign tube_inc[gi] = refill_valid && (refill_coin == 2'(gi + 1));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= CNT_W'(TUBE_INIT);
                    ovf_reg <= 1'b0;
                end else begin
                    ovf_reg <= 1'b0;
                    // Simultaneous refill and payout cancel: the refill lands
                    // in the slot just vacated, so it can never overflow.
                    if (tube_inc[gi] && !tube_dec[gi]) begin
                        if (cnt_reg < CNT_W'(TUBE_MAX))
                            cnt_reg <= cnt_reg + 1'b1;
                        else
                            ovf_reg <= 1'b1;
                    end else if (tube_dec[gi] && !tube_inc[gi]) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
            end

            assign tube_cnt[gi]   = cnt_reg;
            assign tube_ovf[gi]   = ovf_reg;
            assign tube_empty[gi] = (cnt_reg == '0);
            assign tube_low[gi]   = (cnt_reg <= CNT_W'(LOW_THRESH));
        end
    endgenerate

    // Greedy choice: largest coin that fits the remainder and is in stock.
    always_comb begin
        pick_code = 2'b00;
        if (rem_reg >= AMT_W'(20) && tube_cnt[2] != '0)
            pick_code = 2'b11;
        else if (rem_reg >= AMT_W'(10) && tube_cnt[1] != '0)
            pick_code = 2'b10;
        else if (rem_reg >= AMT_W'(5) && tube_cnt[0] != '0)
            pick_code = 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rem_reg        <= '0;
            remaining_reg  <= '0;
            coin_out_reg   <= 2'b00;
            coin_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            short_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        rem_reg       <= req_amount;
                        short_reg     <= 1'b0;
                        remaining_reg <= '0;
                        state_reg     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_code != 2'b00) begin
                        coin_out_reg   <= pick_code;
                        coin_valid_reg <= 1'b1;
                        state_reg      <= EMIT;
                    end else begin
                        done_reg      <= 1'b1;
                        short_reg     <= (rem_reg != '0);
                        remaining_reg <= rem_reg;
                        state_reg     <= DONE;
                    end
                end
                EMIT: begin
                    if (coin_ack) begin
                        rem_reg        <= rem_reg - coin_value(coin_out_reg);
                        coin_out_reg   <= 2'b00;
                        coin_valid_reg <= 1'b0;
                        state_reg      <= SELECT;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (state_reg == IDLE);
    assign coin_out        = coin_out_reg;
    assign coin_valid      = coin_valid_reg;
    assign done            = done_reg;
    assign short           = short_reg;
    assign remaining       = remaining_reg;
    assign refill_overflow = |tube_ovf;
    assign low_change      = |tube_low;

endmodule
